csa_mult_arbiter: RTL
=====================

# csa_mult_arbiter

Two-requester round-robin controller that time-shares one 4-bit carry-save array multiplier. Each requester presents an operand pair with a valid/ready handshake. The arbiter latches the granted pair and drives the multiplier from registers, waits a programmable settle interval, and returns the captured product with the requester ID over a response handshake. It sits between the operand sources (switch/keypad front ends) and the shared `csa_multiplier` instance, which stays purely combinational.

## Interface
- `W`, default 4: operand width; the product is 2·W.
- `SETTLE_CYCLES`, default 1: cycles the multiplier inputs are held before the product is sampled. Legal range is 1..15.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_valid` input 2: bit i means requester i has an operand pair pending.
- `req_ready` output 2: bit i means requester i's pair is accepted this cycle. Combinational; one-hot or zero.
- `req0_m`, `req0_q` input W each: requester 0 operands.
- `req1_m`, `req1_q` input W each: requester 1 operands.
- `mul_m`, `mul_q` output W each: registered operands driven to the external `csa_multiplier`.
- `mul_p` input 2W: product returned from the multiplier.
- `rsp_valid` output 1: the response is valid.
- `rsp_ready` input 1: the consumer accepts the response.
- `rsp_id` output 1: index of the requester that owns `rsp_p`.
- `rsp_p` output 2W: captured product.
- `busy` output 1: high in every state except IDLE.

## Operation
- States are IDLE, BUSY and RESP, encoded in 2 bits. The unused code returns to IDLE.
- Round-robin pointer `rr` (1 bit) holds the preferred requester.

IDLE:
- If only one `req_valid` bit is set, that requester is selected.
- If both are set, requester `rr` is selected.
- `req_ready` is asserted for the selected requester only.
- At the accept edge the arbiter:
  - loads that requester's m and q into `mul_m`/`mul_q`;
  - stores the index in `rsp_id`;
  - loads `cnt` = SETTLE_CYCLES−1;
  - moves to BUSY.

BUSY:
- `req_ready` = 0 and `mul_m`/`mul_q` are held.
- If `cnt`≠0, decrement `cnt`.
- If `cnt`=0, `rsp_p` ← `mul_p`, `rsp_valid` ← 1, and the state moves to RESP.

RESP:
- `rsp_valid`, `rsp_p` and `rsp_id` are held stable until `rsp_ready`=1.
- On the handshake edge: `rsp_valid` ← 0, `rr` ← ~`rsp_id`, state ← IDLE.

Other rules:
- Operands are sampled only at the accept edge. Later changes on `reqN_m`/`reqN_q` and withdrawal of `req_valid` before acceptance have no effect on an issued operation.
- `mul_m`/`mul_q` keep their last values in IDLE and RESP; they do not return to 0.
- Arithmetic is unsigned. `rsp_p` is exactly the 2W-bit `mul_p` sample, with no truncation.
- Only one operation is in flight; there is no queueing. A requester whose valid is ignored keeps waiting.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `rr`=0, `cnt`=0, `mul_m`=`mul_q`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0. `busy`=0 and `req_ready`=0 during reset.
- Reset mid-operation (BUSY or RESP): the transaction is discarded, no response is produced, and the outputs take the values above after that edge.
- Latency: accept at edge E0 → `rsp_valid` high after edge E0+SETTLE_CYCLES.
- Throughput: with `rsp_ready` tied high, one transaction per SETTLE_CYCLES+2 cycles (IDLE, BUSY×S, RESP).
- `rsp_ready` high in the first RESP cycle means RESP lasts exactly one cycle.
- IDLE accept is same-cycle: `req_ready` rises in the same cycle `req_valid` is seen in IDLE.
- `rr` changes only on the response handshake. It does not change on accept or reset-discard.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles with both valids high. Required: `req_ready`=00, `rsp_valid`=0, `mul_m`=`mul_q`=0, `busy`=0.
- Single request, SETTLE=1: req0 (5,5) with `rsp_ready`=1. Required: `req_ready`=01 in the accept cycle, `rsp_valid` 1 cycle later with `rsp_id`=0 and `rsp_p`=25, back in IDLE on the next edge.
- Simultaneous requests: req0 (9,5) and req1 (12,13) held valid from reset. Required: response id0 with 45 first, then id1 with 156. Continuous requests afterwards alternate 0,1,0,1.
- Backpressure: req1 (15,10) with `rsp_ready`=0 for 5 cycles, then 1. Required: `rsp_p`=150 and `rsp_id`=1 stable across all 6 RESP cycles, `req_ready`=00 throughout, and `req_valid`=01 ignored until IDLE.
- Settle and operand stability: SETTLE_CYCLES=4, req0 (0,10); change `req0_m` to 7 after accept. Required: `mul_m` stays 0, `rsp_p`=0, and `rsp_valid` rises exactly 4 edges after accept.
- Reset in BUSY: with SETTLE=4, deassert `rst_n` at BUSY cycle 2. Required: no `rsp_valid` pulse, state IDLE, `rr` unchanged at 0.

Source files
------------

// File: rtl/csa_mult_arbiter.sv
// Two-requester round-robin front end for a shared combinational
// carry-save multiplier. Latches the granted operand pair, holds it on the
// multiplier inputs for SETTLE_CYCLES, then returns the sampled product
// together with the owning requester's index over a valid/ready response.
module csa_mult_arbiter #(
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req0_m,
  input  logic [W-1:0]   req0_q,
  input  logic [W-1:0]   req1_m,
  input  logic [W-1:0]   req1_q,
  output logic [W-1:0]   mul_m,
  output logic [W-1:0]   mul_q,
  input  logic [2*W-1:0] mul_p,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_p,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // The settle counter is sized for the largest legal SETTLE_CYCLES (15).
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       rr;
  logic [3:0] cnt;
  logic       sel;

  // Pick the requester to serve: a lone valid wins, a tie goes to rr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel       = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) sel = rr;
    else                    sel = req_valid[1];
    if (rst_n && (state == IDLE) && (req_valid != 2'b00))
      req_ready = sel ? 2'b10 : 2'b01;
  end

  // Busy reflects any non-idle state; forced low while reset is asserted.
  assign busy = rst_n && (state != IDLE);

  // Control FSM with registered multiplier operands and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cnt       <= '0;
      mul_m     <= '0;
      mul_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            mul_m  <= sel ? req1_m : req0_m;
            mul_q  <= sel ? req1_q : req0_q;
            rsp_id <= sel;
            cnt    <= CNT_INIT;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr        <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
